btn_counter: RTL

Button-driven 8-bit up/down counter for the lab board. It takes two raw push-button inputs, synchronises and debounces them, and detects each press. Each press, and each auto-repeat while a button is held, steps the count shown on the 8 LEDs. It is the user-input counterpart of the free-running LED counter: the same LD display, but stepped from the board buttons instead of a 1 s timebase.

---
 rtl/btn_counter_if.sv | 14 +
 rtl/btn_counter.sv | 112 +++++++++++
 2 files changed

// File: rtl/btn_counter_if.sv
// Button/LED bundle for btn_counter: raw buttons in, registered count and step pulses out.
// The counter sits on the slave side; whatever drives the buttons uses the master side.
interface btn_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             btn_up;
    logic             btn_down;
    logic [WIDTH-1:0] LD;
    logic             up_evt;
    logic             down_evt;

    modport master (output btn_up, output btn_down, input LD, input up_evt, input down_evt);
    modport slave  (input btn_up, input btn_down, output LD, output up_evt, output down_evt);
endinterface

// File: rtl/btn_counter.sv
// Button-stepped up/down counter: per-button synchronizer, debouncer and hold/repeat FSM
// feeding a registered modulo-2^WIDTH count on LD.
module btn_counter #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic          clk,
    input  logic          res,
    btn_counter_if.slave  bus
);
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [1:0]       raw;
    logic [1:0]       fire;
    logic [WIDTH-1:0] ld_q;
    logic             up_q;
    logic             down_q;

    // Channel 0 is the up button, channel 1 the down button.
    assign raw = {bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_path
        logic          sync1;
        logic          sync2;
        logic          deb;
        logic [CW-1:0] stab;
        logic [TW-1:0] timer;
        state_t        state;

        always_ff @(posedge clk) begin
            if (res) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
            end
        end

        always_ff @(posedge clk) begin
            if (res) begin
                deb  <= 1'b0;
                stab <= '0;
            end else if (sync2 != deb) begin
                if (stab == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb  <= ~deb;
                    stab <= '0;
                end else begin
                    stab <= stab + CW'(1);
                end
            end else begin
                stab <= '0;
            end
        end

        // IDLE is only ever occupied with deb low, so deb high there is the rising edge.
        assign fire[i] = deb && ((state == IDLE) || (timer == '0));

        always_ff @(posedge clk) begin
            if (res) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (deb) begin
                            state <= HOLD;
                            timer <= TW'(HOLD_CYCLES - 1);
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!deb) begin
                            state <= IDLE;
                        end else if (timer == '0) begin
                            state <= REPEAT;
                            timer <= TW'(REPEAT_CYCLES - 1);
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ld_q   <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= fire[0];
            down_q <= fire[1];
            case (fire)
                2'b01:   ld_q <= ld_q + WIDTH'(1);
                2'b10:   ld_q <= ld_q - WIDTH'(1);
                default: ld_q <= ld_q;
            endcase
        end
    end

    assign bus.LD       = ld_q;
    assign bus.up_evt   = up_q;
    assign bus.down_evt = down_q;
endmodule
